axi_rd_ctrl_burst: RTL and testbench
====================================

// Module: axi_rd_ctrl_burst
// PURPOSE
//  Read-side counterpart of the DDR AXI write controller. Turns a user read request (rising edge of rd_req)
//  into one AXI read-address handshake, collects the returned burst beats, forwards each beat to the user
//  registered, then pulses rd_done. Sits between the image/feature consumers and the DDR IP AXI read port.
// PARAMETERS
//  ADDR_W     `CTRL_ADDR_WIDTH (28)  AXI/user byte address width
//  DATA_W     `MEM_DQ_WIDTH*8 (256)  beat width
//  LEN_W      4                      burst-length field width; beats per burst = arlen+1 (1..16)
//  TIMEOUT    1024                   max clk_100M cycles from entering ADDR to last beat before abort
// PORTS
//  clk_100M       in   1       system clock, all logic on posedge
//  rstn           in   1       synchronous, active-low reset
//  init_done      in   1       DDR calibration complete; requests ignored while 0
//  rd_req         in   1       user request; rising edge starts a read
//  rd_addr        in   ADDR_W  start address, sampled on rd_req rising edge
//  arlen          in   LEN_W   burst length-1, sampled with rd_addr
//  rd_busy        out  1       high from accepted request until burst completes or aborts
//  rd_done        out  1       1-cycle pulse: burst finished (normal or aborted)
//  rd_err         out  1       sticky: last burst aborted (timeout/length mismatch); cleared on next accept
//  rd_data        out  DATA_W  returned beat, registered
//  rd_data_valid  out  1       1-cycle qualifier per forwarded beat
//  rd_data_last   out  1       set with rd_data_valid on the final forwarded beat
//  axi_araddr     out  ADDR_W  read address
//  axi_arlen      out  LEN_W   read burst length-1
//  axi_arvalid    out  1       address valid
//  axi_arready    in   1       address ready
//  axi_rdata      in   DATA_W  read data beat
//  axi_rvalid     in   1       read beat valid (controller is always ready; no rready)
//  axi_rlast      in   1       last beat of burst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, beat/timeout counters 0, rd_req_d 0. Reset mid-burst drops arvalid
//   next edge; beats still arriving afterwards are ignored (state IDLE).
//  Rise detect: rise = rd_req & ~rd_req_d (rd_req_d registered). Accept = rise & init_done & state==IDLE;
//   rises in other states or with init_done=0 are discarded, never queued.
//  States (one-hot): IDLE, ADDR, DATA, DONE.
//   IDLE->ADDR on accept: latch axi_araddr<=rd_addr, axi_arlen<=arlen; rd_busy<=1; rd_err<=0;
//    axi_arvalid<=1 on the same edge (visible the cycle after rd_req first sampled high).
//   ADDR: hold araddr/arlen/arvalid stable until arvalid&arready; on that edge arvalid<=0, beat_cnt<=0, ->DATA.
//   DATA: each axi_rvalid beat: rd_data<=axi_rdata, rd_data_valid<=1, beat_cnt++;
//    rd_data_last<=1 when beat_cnt==axi_arlen. End on beat with beat_cnt==axi_arlen ->DONE.
//    axi_rlast on an earlier beat, or missing on the final beat: rd_err<=1, still ->DONE at counted end
//    (early rlast ends burst immediately ->DONE with rd_err).
//   DONE: rd_done<=1 for exactly one cycle, rd_busy<=0 on the same edge, ->IDLE. Earliest next accept is
//    the cycle after DONE.
//  Timeout: counter runs in ADDR and DATA; reaching TIMEOUT-1 forces arvalid<=0, rd_err<=1, ->DONE.
//  rd_data_valid/rd_data_last are single-cycle pulses; rd_data holds last beat between pulses.
//  Beat counter LEN_W bits, never wraps within a legal burst (max 15). rvalid seen in IDLE/ADDR/DONE ignored.
//  Latency: rd_req edge -> arvalid 1 cycle; axi beat -> rd_data_valid 1 cycle; final beat -> rd_done 2 cycles.
// STRUCTURE
//  Shared package/include p_ddr.v: CTRL_ADDR_WIDTH, MEM_DQ_WIDTH; add RD_TIMEOUT default there.
//  State encoding local. Single flat module; no sub-module needed (edge detect and counters inline).
// TESTING
//  1 init_done=1, rd_req rise, addr 0x0001000, arlen 3, arready immediate, 4 rvalid beats (rlast on 4th)
//    -> arvalid 1 cycle later, 4 rd_data_valid pulses with matching data, rd_data_last on 4th, rd_done once, rd_err 0.
//  2 arready held low 5 cycles -> arvalid and araddr/arlen stable all 5 cycles, drops the edge after handshake.
//  3 rvalid gaps (beat, 3 idle, beat) with arlen 1 -> exactly 2 valid pulses, rd_busy high throughout, no extra done.
//  4 rd_req rise while busy and while init_done=0 -> ignored: no second arvalid, araddr unchanged.
//  5 arlen 7, rlast on beat 3 -> rd_err=1, rd_done pulse, busy clears; next request clears rd_err.
//  6 no rvalid after handshake, TIMEOUT=64 -> rd_err=1, rd_done pulse; rstn low mid-DATA -> all outputs 0 next edge.

Source files
------------

// File: rtl/axi_rd_ctrl_burst_pkg.sv
// axi_rd_ctrl_burst_pkg: shared DDR widths, read timeout default and command types
package axi_rd_ctrl_burst_pkg;
  localparam int CTRL_ADDR_WIDTH = 28;
  localparam int MEM_DQ_WIDTH = 32;
  localparam int RD_TIMEOUT = 1024;
  localparam int ADDR_W = CTRL_ADDR_WIDTH;
  localparam int DATA_W = MEM_DQ_WIDTH * 8;
  localparam int LEN_W = 4;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef struct packed {
    addr_t addr;
    len_t  len;
  } rd_cmd_t;
endpackage

// File: rtl/axi_rd_ctrl_burst_if.sv
// axi_rd_ctrl_burst_if: AXI read address/data channel bundle between controller and DDR IP
interface axi_rd_ctrl_burst_if;
  import axi_rd_ctrl_burst_pkg::*;
  addr_t araddr;
  len_t  arlen;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  logic  rvalid;
  logic  rlast;
  modport master (output araddr, arlen, arvalid, input arready, rdata, rvalid, rlast);
  modport slave  (input araddr, arlen, arvalid, output arready, rdata, rvalid, rlast);
endinterface

// File: rtl/axi_rd_ctrl_burst.sv
// axi_rd_ctrl_burst: turns a rd_req rising edge into one AXI read burst and forwards the beats
module axi_rd_ctrl_burst
  import axi_rd_ctrl_burst_pkg::*;
#(
  parameter int TIMEOUT = RD_TIMEOUT
) (
  input  logic        clk_100M,
  input  logic        rstn,
  input  logic        init_done_i,
  input  logic        rd_req_i,
  input  addr_t       rd_addr_i,
  input  len_t        arlen_i,
  output logic        rd_busy_o,
  output logic        rd_done_o,
  output logic        rd_err_o,
  output data_t       rd_data_o,
  output logic        rd_data_valid_o,
  output logic        rd_data_last_o,
  axi_rd_ctrl_burst_if.master axi
);
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_ADDR = 4'b0010;
  localparam logic [3:0] S_DATA = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;
  localparam int TW = $clog2(TIMEOUT);
  logic [3:0] state_q, state_d;
  logic rd_req_q;
  rd_cmd_t cmd_q, cmd_d;
  logic arvalid_q, arvalid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic dv_q, dv_d, dl_q, dl_d;
  data_t data_q, data_d;
  len_t beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic accept, tmo_hit, beat_end;
  assign accept = rd_req_i & ~rd_req_q & init_done_i & (state_q == S_IDLE);
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign beat_end = beat_q == cmd_q.len;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    arvalid_d = arvalid_q;
    busy_d = busy_q;
    err_d = err_q;
    data_d = data_q;
    beat_d = beat_q;
    done_d = 1'b0;
    dv_d = 1'b0;
    dl_d = 1'b0;
    tmo_d = (state_q == S_ADDR || state_q == S_DATA) ? tmo_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: if (accept) begin
        cmd_d = '{addr: rd_addr_i, len: arlen_i};
        busy_d = 1'b1;
        err_d = 1'b0;
        arvalid_d = 1'b1;
        state_d = S_ADDR;
      end
      S_ADDR: if (tmo_hit) begin
        arvalid_d = 1'b0;
        err_d = 1'b1;
        state_d = S_DONE;
      end else if (axi.arready) begin
        arvalid_d = 1'b0;
        beat_d = '0;
        state_d = S_DATA;
      end
      S_DATA: if (tmo_hit) begin
        err_d = 1'b1;
        state_d = S_DONE;
      end else if (axi.rvalid) begin
        data_d = axi.rdata;
        dv_d = 1'b1;
        dl_d = beat_end;
        beat_d = beat_q + 1'b1;
        // burst ends at the counted last beat or an early rlast; any disagreement is an error
        if (beat_end || axi.rlast) begin
          err_d = beat_end ^ axi.rlast;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_100M) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rd_req_q <= 1'b0;
      cmd_q <= '0;
      arvalid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
      dv_q <= 1'b0;
      dl_q <= 1'b0;
      beat_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      rd_req_q <= rd_req_i;
      cmd_q <= cmd_d;
      arvalid_q <= arvalid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      data_q <= data_d;
      dv_q <= dv_d;
      dl_q <= dl_d;
      beat_q <= beat_d;
      tmo_q <= tmo_d;
    end
  end
  assign axi.araddr = cmd_q.addr;
  assign axi.arlen = cmd_q.len;
  assign axi.arvalid = arvalid_q;
  assign rd_busy_o = busy_q;
  assign rd_done_o = done_q;
  assign rd_err_o = err_q;
  assign rd_data_o = data_q;
  assign rd_data_valid_o = dv_q;
  assign rd_data_last_o = dl_q;
endmodule

// File: tb/tb_axi_rd_ctrl_burst.sv
// tb_axi_rd_ctrl_burst: directed scoreboard bench for the AXI burst read controller
module tb_axi_rd_ctrl_burst;
  import axi_rd_ctrl_burst_pkg::*;
  typedef struct {
    data_t d;
    logic  l;
  } beat_t;
  logic clk_100M = 1'b0;
  logic rstn, init_done, rd_req;
  addr_t rd_addr;
  len_t arlen;
  logic rd_busy, rd_done, rd_err, rd_data_valid, rd_data_last;
  data_t rd_data;
  axi_rd_ctrl_burst_if axi ();
  int n_chk = 0, n_fail = 0;
  logic mon_en = 1'b0;
  rd_cmd_t ar_q[$];
  beat_t beat_q[$];
  logic done_q[$];
  axi_rd_ctrl_burst #(.TIMEOUT(64)) dut (
    .clk_100M(clk_100M), .rstn(rstn), .init_done_i(init_done), .rd_req_i(rd_req),
    .rd_addr_i(rd_addr), .arlen_i(arlen), .rd_busy_o(rd_busy), .rd_done_o(rd_done),
    .rd_err_o(rd_err), .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid),
    .rd_data_last_o(rd_data_last), .axi(axi)
  );
  always #5 clk_100M = ~clk_100M;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic data_t pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {8{w}};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask
  task automatic req(input addr_t a, input len_t l);
    rd_req = 1'b1;
    rd_addr = a;
    arlen = l;
    ar_q.push_back('{addr: a, len: l});
    tick(1);
    rd_req = 1'b0;
  endtask
  task automatic beat(input data_t d, input logic last, input logic exp_last);
    axi.rvalid = 1'b1;
    axi.rdata = d;
    axi.rlast = last;
    beat_q.push_back('{d: d, l: exp_last});
    tick(1);
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
  endtask
  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && (ar_q.size() + beat_q.size() + done_q.size()) != 0; i++) tick(1);
    tick(2);
    chk(name, 32'(ar_q.size() + beat_q.size() + done_q.size()), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, rd_busy, 0);
    chk({tag, "_done"}, rd_done, 0);
    chk({tag, "_err"}, rd_err, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_dvalid"}, rd_data_valid, 0);
    chk({tag, "_dlast"}, rd_data_last, 0);
    chk({tag, "_araddr"}, axi.araddr, 0);
    chk({tag, "_arlen"}, axi.arlen, 0);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
  endtask
  always @(negedge clk_100M) if (mon_en) begin
    if (axi.arvalid) begin
      chk("ar_expected", ar_q.size() != 0, 1);
      if (ar_q.size() != 0) begin
        chk("araddr", axi.araddr, ar_q[0].addr);
        chk("arlen", axi.arlen, ar_q[0].len);
        if (axi.arready) void'(ar_q.pop_front());
      end
    end
    if (rd_data_valid) begin
      chk("beat_expected", beat_q.size() != 0, 1);
      if (beat_q.size() != 0) begin
        chk("rd_data", rd_data, beat_q[0].d);
        chk("rd_data_last", rd_data_last, beat_q[0].l);
        void'(beat_q.pop_front());
      end
    end else if (rd_data_last) chk("last_without_valid", rd_data_last, 0);
    if (rd_done) begin
      chk("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) begin
        chk("done_err", rd_err, done_q[0]);
        chk("done_busy", rd_busy, 0);
        void'(done_q.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rstn = 1'b0;
    init_done = 1'b0;
    rd_req = 1'b0;
    rd_addr = '0;
    arlen = '0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = '0;
    axi.rlast = 1'b0;
    tick(3);
    chk_zero("reset");
    rstn = 1'b1;
    init_done = 1'b1;
    axi.arready = 1'b1;
    mon_en = 1'b1;
    tick(2);
    // 4-beat burst, immediate arready
    done_q.push_back(1'b0);
    rd_req = 1'b1;
    rd_addr = 28'h0001000;
    arlen = 4'd3;
    ar_q.push_back('{addr: 28'h0001000, len: 4'd3});
    chk("t1_arvalid_pre", axi.arvalid, 0);
    tick(1);
    rd_req = 1'b0;
    chk("t1_arvalid_post", axi.arvalid, 1);
    chk("t1_busy", rd_busy, 1);
    tick(1);
    for (int i = 0; i < 4; i++) beat(pat(i), i == 3, i == 3);
    drain("t1_drain", 20);
    chk("t1_err", rd_err, 0);
    // arready withheld for 5 cycles
    axi.arready = 1'b0;
    done_q.push_back(1'b0);
    req(28'h0003000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", axi.arvalid, 1);
      tick(1);
    end
    axi.arready = 1'b1;
    tick(1);
    chk("t2_arvalid_drop", axi.arvalid, 0);
    beat(pat(10), 1'b1, 1'b1);
    drain("t2_drain", 20);
    // gapped beats
    done_q.push_back(1'b0);
    req(28'h00A0040, 4'd1);
    tick(1);
    beat(pat(20), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_busy_gap", rd_busy, 1);
      tick(1);
    end
    beat(pat(21), 1'b1, 1'b1);
    chk("t3_busy_end", rd_busy, 1);
    drain("t3_drain", 20);
    // rises while busy and while uncalibrated are dropped
    done_q.push_back(1'b0);
    req(28'h0004000, 4'd1);
    tick(1);
    rd_req = 1'b1;
    rd_addr = 28'h0ABCDE0;
    tick(1);
    rd_req = 1'b0;
    chk("t4_araddr_busy", axi.araddr, 28'h0004000);
    chk("t4_arvalid_busy", axi.arvalid, 0);
    beat(pat(30), 1'b0, 1'b0);
    beat(pat(31), 1'b1, 1'b1);
    drain("t4_drain", 20);
    init_done = 1'b0;
    rd_req = 1'b1;
    rd_addr = 28'h0111110;
    tick(1);
    rd_req = 1'b0;
    tick(3);
    chk("t4_arvalid_noinit", axi.arvalid, 0);
    chk("t4_busy_noinit", rd_busy, 0);
    chk("t4_araddr_noinit", axi.araddr, 28'h0004000);
    init_done = 1'b1;
    // early rlast on beat 3 of 8
    done_q.push_back(1'b1);
    req(28'h0005000, 4'd7);
    tick(1);
    beat(pat(40), 1'b0, 1'b0);
    beat(pat(41), 1'b0, 1'b0);
    beat(pat(42), 1'b1, 1'b0);
    drain("t5_drain", 20);
    chk("t5_err_sticky", rd_err, 1);
    chk("t5_busy", rd_busy, 0);
    // timeout with no data; accept clears the sticky error
    done_q.push_back(1'b1);
    req(28'h0006000, 4'd0);
    chk("t6_err_cleared", rd_err, 0);
    drain("t6_drain", 120);
    chk("t6_err_timeout", rd_err, 1);
    chk("t6_busy", rd_busy, 0);
    // reset in the middle of a burst
    req(28'h0007000, 4'd3);
    tick(1);
    beat(pat(50), 1'b0, 1'b0);
    rstn = 1'b0;
    axi.rvalid = 1'b1;
    axi.rdata = pat(51);
    tick(1);
    mon_en = 1'b0;
    axi.rvalid = 1'b0;
    chk_zero("midrst");
    rstn = 1'b1;
    tick(1);
    axi.rvalid = 1'b1;
    axi.rdata = pat(52);
    tick(1);
    axi.rvalid = 1'b0;
    chk("idle_beat_ignored", rd_data_valid, 0);
    chk("idle_data_held", rd_data, 0);
    mon_en = 1'b1;
    drain("final_drain", 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
